// File: rtl/booth_mul_arbiter.sv
// Round-robin sequencer sharing one combinational radix-4 Booth multiplier.
// Optional BOOTH_ARB_STATS_EN adds op_count (completed response handshakes).

module booth_multiplier (
    input  logic signed [7:0]  a_i,
    input  logic signed [7:0]  b_i,
    output logic signed [15:0] p_o
);
    logic        [8:0]  bx;
    logic signed [15:0] ae;
    logic signed [15:0] pp;
    logic signed [15:0] acc;

    always_comb begin
        bx  = {b_i, 1'b0};
        ae  = {{8{a_i[7]}}, a_i};
        acc = '0;
        pp  = '0;
        // Each 3-bit window of b selects 0, +-A or +-2A, weighted by 4^j.
        for (int j = 0; j < 4; j++) begin
            case (bx[2*j +: 3])
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae <<< 1;
                3'b100:         pp = -(ae <<< 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            acc = acc + (pp <<< (2 * j));
        end
        p_o = acc;
    end
endmodule

module booth_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_product,
`ifdef BOOTH_ARB_STATS_EN
    output logic [15:0]       op_count,
`endif
    output logic [IDW-1:0]    rsp_id
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     grant;
    logic               found;
    logic               hs_req;
    logic               hs_rsp;
    logic signed [7:0]  a_q, b_q;
    logic [IDW-1:0]     id_q;
    logic signed [15:0] prod;
    logic [15:0]        prod_q;
    logic [IDW-1:0]     rid_q;
    logic               rvalid_q;

    // Circular search for the first valid requester starting at ptr.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    assign hs_req = (state_q == IDLE) && found;
    assign hs_rsp = (state_q == RESP) && rvalid_q && rsp_ready;
    assign ptr_d  = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = MUL;
            MUL:     state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (hs_req) req_ready[grant] = 1'b1;
    end

    booth_multiplier u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            prod_q   <= '0;
            rid_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (hs_req) begin
                a_q   <= req_a[8*grant +: 8];
                b_q   <= req_b[8*grant +: 8];
                id_q  <= grant;
                ptr_q <= ptr_d;
            end
            if (state_q == MUL) begin
                prod_q   <= prod;
                rid_q    <= id_q;
                rvalid_q <= 1'b1;
            end else if (hs_rsp) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef BOOTH_ARB_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)         cnt_q <= '0;
        else if (hs_rsp) cnt_q <= cnt_q + 16'd1;
    end

    assign op_count = cnt_q;
`endif

    assign rsp_valid   = rvalid_q;
    assign rsp_product = prod_q;
    assign rsp_id      = rid_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: grant order, latency, backpressure,
// reset abort and signed corner products (op_count when BOOTH_ARB_STATS_EN).

module tb_booth_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_product;
    logic [1:0]  rsp_id;
`ifdef BOOTH_ARB_STATS_EN
    logic [15:0] op_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    booth_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
`ifdef BOOTH_ARB_STATS_EN
        .op_count    (op_count),
`endif
        .rsp_id      (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[8*i +: 8] = 8'(a);
        req_b[8*i +: 8] = 8'(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0]  exp_gnt [6];
    logic [1:0]  exp_id  [4];
    logic [15:0] exp_p   [4];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        do_reset();
        #1;
        chk("rst_rvalid", 16'(rsp_valid), 16'd0);
        chk("rst_rready", 16'(req_ready), 16'd0);
        chk("rst_prod", rsp_product, 16'd0);
        chk("rst_id", 16'(rsp_id), 16'd0);

        // 1: single request 13*3
        set_op(0, 13, 3);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        chk("t1_gnt", 16'(req_ready), 16'b0001);
        tick();
        req_valid = '0;
        #1;
        chk("t1_mul_ready", 16'(req_ready), 16'd0);
        chk("t1_mul_rvalid", 16'(rsp_valid), 16'd0);
        tick();
        chk("t1_rvalid", 16'(rsp_valid), 16'd1);
        chk("t1_prod", rsp_product, 16'd39);
        chk("t1_id", 16'(rsp_id), 16'd0);
        tick();
        chk("t1_done", 16'(rsp_valid), 16'd0);

        // 2: all four valid from ptr=0
        do_reset();
        set_op(0, -5, 4);
        set_op(1, 7, -6);
        set_op(2, -8, -2);
        set_op(3, 127, 1);
        exp_id[0] = 2'd0; exp_p[0] = 16'(-20);
        exp_id[1] = 2'd1; exp_p[1] = 16'(-42);
        exp_id[2] = 2'd2; exp_p[2] = 16'd16;
        exp_id[3] = 2'd3; exp_p[3] = 16'd127;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_gnt", 16'(req_ready), 16'(4'b0001 << i));
            tick();
            req_valid[i] = 1'b0;
            tick();
            chk("t2_id", 16'(rsp_id), 16'(exp_id[i]));
            chk("t2_prod", rsp_product, exp_p[i]);
            tick();
            #1;
        end
        chk("t2_idle", 16'(req_ready), 16'd0);

        // 3: backpressure with req2 waiting
        set_op(1, 0, -5);
        set_op(2, 3, 3);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        #1;
        chk("t3_gnt1", 16'(req_ready), 16'b0010);
        tick();
        req_valid[1] = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_v", 16'(rsp_valid), 16'd1);
            chk("t3_hold_p", rsp_product, 16'd0);
            chk("t3_hold_id", 16'(rsp_id), 16'd1);
            chk("t3_hold_rdy", 16'(req_ready), 16'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_rdy_resp", 16'(req_ready), 16'd0);
        tick();
        chk("t3_gnt2", 16'(req_ready), 16'b0100);
        chk("t3_v_low", 16'(rsp_valid), 16'd0);
        tick();
        req_valid[2] = 1'b0;
        tick();
        chk("t3_prod2", rsp_product, 16'd9);
        chk("t3_id2", 16'(rsp_id), 16'd2);
        tick();

        // 4: fairness, ptr=3 so search wraps to 0 first
        set_op(0, 2, 5);
        set_op(2, -3, 7);
        for (int i = 0; i < 6; i++)
            exp_gnt[i] = (i % 2 == 0) ? 4'b0001 : 4'b0100;
        req_valid = 4'b0101;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("t4_gnt", 16'(req_ready), 16'(exp_gnt[i]));
            tick();
            tick();
            chk("t4_id", 16'(rsp_id), (i % 2 == 0) ? 16'd0 : 16'd2);
            chk("t4_prod", rsp_product,
                (i % 2 == 0) ? 16'd10 : 16'(-21));
            tick();
            #1;
        end
        req_valid = '0;

        // 5: reset during MUL of req3, then signed corners
        set_op(3, -128, -128);
        req_valid = 4'b1000;
        #1;
        chk("t5_gnt3", 16'(req_ready), 16'b1000);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_abort_v", 16'(rsp_valid), 16'd0);
        chk("t5_abort_p", rsp_product, 16'd0);
        tick();
        tick();
        chk("t5_no_rsp", 16'(rsp_valid), 16'd0);
        set_op(0, -128, -128);
        set_op(3, -128, 127);
        req_valid = 4'b1001;
        #1;
        chk("t5_ptr0", 16'(req_ready), 16'b0001);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("t5_p_sq", rsp_product, 16'd16384);
        chk("t5_id0", 16'(rsp_id), 16'd0);
        tick();
        #1;
        chk("t5_gnt3b", 16'(req_ready), 16'b1000);
        tick();
        req_valid[3] = 1'b0;
        tick();
        chk("t5_p_neg", rsp_product, 16'(-16256));
        chk("t5_id3", 16'(rsp_id), 16'd3);
        tick();

        // One more op so three complete after the last reset
        set_op(1, -1, -1);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        chk("t6_prod", rsp_product, 16'd1);
        chk("t6_id", 16'(rsp_id), 16'd1);
        tick();
        chk("t6_done", 16'(rsp_valid), 16'd0);
`ifdef BOOTH_ARB_STATS_EN
        chk("t6_opcnt", op_count, 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
